// File: rtl/ins_cache_dm_pkg.sv
// Shared types and derived-width helpers for the direct-mapped instruction cache.
package ins_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int byte_w(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int word_w, input int lines, input int words);
    return addr_w - idx_w(lines) - off_w(words) - byte_w(word_w);
  endfunction

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_LINES  = 4;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_TAG_W  = tag_w(DEF_ADDR_W, DEF_WORD_W, DEF_LINES, DEF_WORDS);

  // Line layout at the default geometry; the cache keeps the same fields in per-field arrays.
  typedef struct packed {
    logic                             valid;
    logic [DEF_TAG_W-1:0]             tag;
    logic [DEF_WORDS*DEF_WORD_W-1:0]  data;
  } line_t;

endpackage

// File: rtl/ins_cache_dm_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface ins_cache_dm_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) ();
  // Fetch: ireq/iaddr held while ostall=1; ohit is a one-cycle result pulse.
  // Refill: mem_req is a level held until the single-cycle mem_valid carrying the line.
  logic                    ireq;
  logic [ADDR_W-1:0]       iaddr;
  logic                    flush;
  logic                    ohit;
  logic [WORD_W-1:0]       oins;
  logic                    ostall;
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_valid;
  logic [WORDS*WORD_W-1:0] mem_data;

  modport master (
    output ireq, iaddr, flush, mem_valid, mem_data,
    input  ohit, oins, ostall, mem_req, mem_addr
  );

  modport slave (
    input  ireq, iaddr, flush, mem_valid, mem_data,
    output ohit, oins, ostall, mem_req, mem_addr
  );
endinterface

// File: rtl/ins_cache_dm_sat_counter.sv
// Counter that stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ins_cache_dm.sv
// Direct-mapped instruction cache: registered hits, single-line refill on miss, flush, perf counters.
module ins_cache_dm
  import ins_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINES  = 4,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  ins_cache_dm_if.slave    bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [1:0]       state
);
  localparam int BYTE_W = byte_w(WORD_W);
  localparam int OFF_W  = off_w(WORDS);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, WORD_W, LINES, WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << (OFF_W + BYTE_W)) - ADDR_W'(1));

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MISS = ST_MISS;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [WORDS*WORD_W-1:0] data_q [LINES];

  logic [1:0]        state_q;
  logic              flush_pend_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              ohit_q, ostall_q, mem_req_q;
  logic [WORD_W-1:0] oins_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [TAG_W-1:0]  in_tag, req_tag;
  logic [IDX_W-1:0]  in_idx, req_idx;
  logic [OFF_W-1:0]  in_off, req_off;
  logic              hit, accept;
  logic [WORD_W-1:0] hit_word, refill_word;

  assign in_tag  = bus.iaddr[ADDR_W-1 -: TAG_W];
  assign in_idx  = bus.iaddr[BYTE_W+OFF_W +: IDX_W];
  assign in_off  = bus.iaddr[BYTE_W +: OFF_W];
  assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr_q[BYTE_W+OFF_W +: IDX_W];
  assign req_off = req_addr_q[BYTE_W +: OFF_W];

  assign hit         = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign accept      = (state_q == S_IDLE) && !bus.flush && bus.ireq;
  assign hit_word    = data_q[in_idx][in_off*WORD_W +: WORD_W];
  assign refill_word = bus.mem_data[req_off*WORD_W +: WORD_W];

  // Refill always uses the address captured at the miss, not the live iaddr.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_MISS) && bus.mem_valid) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      ohit_q       <= 1'b0;
      oins_q       <= '0;
      ostall_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      req_addr_q   <= '0;
    end else begin
      ohit_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.flush) begin
            valid_q <= '0;
          end else if (bus.ireq) begin
            if (hit) begin
              ohit_q <= 1'b1;
              oins_q <= hit_word;
            end else begin
              ostall_q   <= 1'b1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= bus.iaddr & LINE_MASK;
              req_addr_q <= bus.iaddr;
              state_q    <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (bus.flush) flush_pend_q <= 1'b1;
          if (bus.mem_valid) begin
            valid_q[req_idx] <= 1'b1;
            oins_q           <= refill_word;
            ohit_q           <= 1'b1;
            ostall_q         <= 1'b0;
            mem_req_q        <= 1'b0;
            state_q          <= S_RESP;
          end
        end
        S_RESP: begin
          // A flush seen during the refill lands here, after the refilled word was returned.
          if (flush_pend_q || bus.flush) valid_q <= '0;
          flush_pend_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ohit     = ohit_q;
  assign bus.oins     = oins_q;
  assign bus.ostall   = ostall_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign state        = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && hit),
    .cnt (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && !hit),
    .cnt (miss_cnt)
  );
endmodule

// File: tb/tb_ins_cache_dm.sv
// Randomized scoreboard bench for ins_cache_dm against a line-address cache model.
module tb_ins_cache_dm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ins_cache_dm_if #(.ADDR_W(32), .WORD_W(32), .WORDS(4)) bus ();

  logic [31:0] hit_cnt, miss_cnt;
  logic [1:0]  state;

  ins_cache_dm #(.ADDR_W(32), .WORD_W(32), .LINES(4), .WORDS(4), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .state    (state)
  );

  logic       sat_inc = 1'b0;
  logic [2:0] sat_cnt;
  sat_counter #(.CNT_W(3)) u_sat (.clk(clk), .rst(rst), .inc(sat_inc), .cnt(sat_cnt));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: backing memory plus which line address each slot holds.
  logic [31:0] mem_pre [logic [31:0]];
  bit          m_valid [4];
  logic [31:0] m_line  [4];
  int          m_hits, m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem_pre.exists(wa)) return mem_pre[wa];
    return {wa[15:0] ^ 16'hC0DE, wa[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.ohit === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ohit: got oins %h expected no response", bus.oins);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.oins !== e) begin
          errors++;
          $display("FAIL oins: got %h expected %h", bus.oins, e);
        end
      end
    end
  end

  task automatic finish_txn();
    @(negedge clk); #1;
    check("resp_drained", exp_q.size(), 0);
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
  endtask

  task automatic fetch(input logic [31:0] a, input bit flush_mid);
    logic [31:0]  line;
    logic [127:0] ld;
    int           idx, wait_n;
    bit           is_hit;
    line   = a & ~32'hF;
    idx    = int'((a >> 4) & 32'h3);
    is_hit = m_valid[idx] && (m_line[idx] == line);
    @(negedge clk);
    bus.ireq  = 1'b1;
    bus.iaddr = a;
    @(posedge clk); #1;
    if (is_hit) begin
      m_hits++;
      exp_q.push_back(mem_word(a & ~32'h3));
      bus.ireq = 1'b0;
      check("hit_no_stall", bus.ostall, 0);
      check("hit_no_req", bus.mem_req, 0);
    end else begin
      m_misses++;
      check("miss_stall", bus.ostall, 1);
      check("miss_req", bus.mem_req, 1);
      check("miss_addr", bus.mem_addr, line);
      if (flush_mid) begin
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
      end
      wait_n = $urandom_range(0, 3);
      for (int i = 0; i < wait_n; i++) begin
        @(posedge clk); #1;
      end
      check("miss_hold_req", bus.mem_req, 1);
      for (int k = 0; k < 4; k++) ld[k*32 +: 32] = mem_word(line + 32'(4 * k));
      bus.mem_valid = 1'b1;
      bus.mem_data  = ld;
      @(posedge clk); #1;
      bus.mem_valid = 1'b0;
      bus.mem_data  = {4{$urandom()}};
      bus.ireq      = 1'b0;
      m_valid[idx]  = 1'b1;
      m_line[idx]   = line;
      exp_q.push_back(mem_word(a & ~32'h3));
      check("resp_no_stall", bus.ostall, 0);
      check("resp_req_low", bus.mem_req, 0);
      @(posedge clk); #1;
      check("ohit_one_cycle", bus.ohit, 0);
      if (flush_mid) model_clear();
    end
    finish_txn();
  endtask

  task automatic hit_burst(input int n);
    int cand[$];
    int pick;
    for (int i = 0; i < 4; i++) if (m_valid[i]) cand.push_back(i);
    if (cand.size() == 0) return;
    @(negedge clk);
    bus.ireq = 1'b1;
    for (int j = 0; j < n; j++) begin
      pick = cand[$urandom_range(0, cand.size() - 1)];
      bus.iaddr = m_line[pick] | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      @(posedge clk); #1;
      m_hits++;
      exp_q.push_back(mem_word(bus.iaddr & ~32'h3));
    end
    bus.ireq = 1'b0;
    finish_txn();
  endtask

  task automatic flush_idle();
    @(negedge clk);
    bus.flush = 1'b1;
    bus.ireq  = 1'($urandom_range(0, 1));
    bus.iaddr = $urandom_range(0, 255);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.ireq  = 1'b0;
    model_clear();
    finish_txn();
  endtask

  task automatic reset_mid(input logic [31:0] a);
    if (m_valid[int'((a >> 4) & 32'h3)]) flush_idle();
    @(negedge clk);
    bus.ireq  = 1'b1;
    bus.iaddr = a;
    @(posedge clk); #1;
    check("rm_stall", bus.ostall, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ireq = 1'b0;
    model_clear();
    m_hits   = 0;
    m_misses = 0;
    check("rm_req_low", bus.mem_req, 0);
    check("rm_stall_low", bus.ostall, 0);
    check("rm_state", state, 0);
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_data  = {4{32'hDEAD_BEEF}};
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    check("rm_stray_state", state, 0);
    finish_txn();
  endtask

  initial begin
    bus.ireq      = 1'b0;
    bus.iaddr     = '0;
    bus.flush     = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    m_hits        = 0;
    m_misses      = 0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      mem_pre[32'h40  + 32'(4 * k)] = 32'hA0 + 32'(k);
      mem_pre[32'h440 + 32'(4 * k)] = 32'hB0 + 32'(k);
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ohit", bus.ohit, 0);
    check("rst_oins", bus.oins, 0);
    check("rst_ostall", bus.ostall, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_state", state, 0);
    rst = 1'b0;

    fetch(32'h48, 1'b0);
    fetch(32'h44, 1'b0);
    check("hit_cnt_1", hit_cnt, 1);
    fetch(32'h448, 1'b0);
    fetch(32'h48, 1'b0);
    check("miss_cnt_3", miss_cnt, 3);
    flush_idle();
    fetch(32'h44, 1'b0);
    check("flush_hit_cnt_kept", hit_cnt, 1);
    flush_idle();
    fetch(32'h48, 1'b1);
    fetch(32'h44, 1'b0);
    reset_mid(32'h48);
    check("rm_cnt_zero", hit_cnt + miss_cnt, 0);

    for (int it = 0; it < 150; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) flush_idle();
      else if (r <= 2) hit_burst($urandom_range(1, 5));
      else if (r == 3 && $urandom_range(0, 3) == 0) reset_mid($urandom_range(0, 255));
      else fetch($urandom_range(0, 255), $urandom_range(0, 5) == 0);
    end

    sat_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("sat_mid", sat_cnt, 3);
    repeat (7) @(posedge clk);
    #1;
    check("sat_top", sat_cnt, 7);
    sat_inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ins_cache_dm.md
Name: ins_cache_dm

Overview:
Parametrised direct-mapped instruction cache between the PC/fetch stage and instruction memory. Serves hits with one-cycle registered latency. On a miss it runs an explicit request/valid refill handshake to memory, writes the full line with the tag taken from the requested address, then returns the requested word. Adds whole-cache flush and saturating hit/miss counters for performance bring-up.

Parameters:
ADDR_W, 32, byte-address width
WORD_W, 32, instruction width (power of two, >= 8)
LINES, 4, number of cache lines (power of two, >= 2)
WORDS, 4, words per line (power of two, >= 2)
CNT_W, 32, width of hit/miss counters
Derived: BYTE_W = log2(WORD_W/8), OFF_W = log2(WORDS), IDX_W = log2(LINES), TAG_W = ADDR_W - IDX_W - OFF_W - BYTE_W

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
ireq  in  1  fetch request; iaddr is valid
iaddr  in  ADDR_W  fetch byte address; held stable by requester while ostall=1
flush  in  1  invalidate all lines
ohit  out  1  one-cycle pulse: oins valid for the accepted request
oins  out  WORD_W  returned instruction
ostall  out  1  miss in progress; requester must hold ireq/iaddr
mem_req  out  1  refill request; level, held until mem_valid
mem_addr  out  ADDR_W  line-aligned refill address (low OFF_W+BYTE_W bits zero)
mem_valid  in  1  refill data valid, one cycle
mem_data  in  WORDS*WORD_W  refill line; word k at bits [k*WORD_W +: WORD_W]
hit_cnt  out  CNT_W  saturating count of hits
miss_cnt  out  CNT_W  saturating count of misses

Behaviour:
- Address split: tag = iaddr[ADDR_W-1 -: TAG_W]; idx = next IDX_W bits; off = next OFF_W bits; byte bits ignored.
- Storage per line: valid bit, TAG_W tag, WORDS*WORD_W data. No reset of the data array is needed; valid bits are cleared.
- Reset (rst=1 at edge): all valid bits = 0, state = IDLE, ohit = 0, oins = 0, ostall = 0, mem_req = 0, mem_addr = 0, counters = 0, flush_pend = 0. Reset mid-refill abandons the refill; any later mem_valid is ignored.
- FSM states IDLE, MISS, RESP.
- IDLE, flush=1: clear all valid bits; ireq in the same cycle is ignored; ohit = 0.
- IDLE, ireq=1, hit (valid && tag match): next cycle ohit = 1, oins = line word[off], hit_cnt += 1. Back-to-back hits give one result per cycle.
- IDLE, ireq=1, miss: next cycle ostall = 1, mem_req = 1, mem_addr = {tag, idx, 0}, miss_cnt += 1, go to MISS; ohit = 0.
- MISS: hold mem_req/mem_addr. When mem_valid = 1: write the line (valid = 1, tag from iaddr, data = mem_data), register oins = mem_data word[off], go to RESP. Next cycle: mem_req = 0, ohit = 1, ostall = 0.
- RESP: one cycle, returns to IDLE; ireq is not accepted in RESP. Requester re-presents the next address in IDLE.
- flush in MISS or RESP sets flush_pend. The refill completes and its word is still returned. Valid bits are cleared on the cycle RESP returns to IDLE, then flush_pend = 0.
- mem_valid outside MISS is ignored.
- ohit is 0 in every cycle not stated above. oins holds its last value when ohit = 0.
- Counters saturate at all-ones and do not wrap.
- ireq changing while ostall = 1 is a protocol violation; the cache uses the address registered at the miss.

Decomposition:
- Shared package ins_cache_pkg: FSM state enum (IDLE, MISS, RESP), derived-width functions (clog2-based), and a line struct typedef (valid, tag, data).
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, rst, inc, cnt), instantiated twice.

Test Plan:
- Cold miss: rst, then ireq iaddr=0x48 -> next cycle ostall=1, mem_req=1, mem_addr=0x40. mem_valid after 3 cycles with words {0xA0,0xA1,0xA2,0xA3} -> one cycle later ohit=1, oins=0xA2, ostall=0, miss_cnt=1.
- Hit: after the cold miss, ireq iaddr=0x44 -> next cycle ohit=1, oins=0xA1, hit_cnt=1, mem_req stays 0.
- Conflict: ireq 0x448 (idx 0, tag differs) -> miss, mem_addr=0x440. Refill {0xB0..0xB3} -> oins=0xB2. Then ireq 0x48 -> miss again; miss_cnt=3.
- Flush idle: fill line 0, pulse flush, then ireq 0x44 -> miss, mem_req=1, hit_cnt unchanged.
- Flush during refill: flush in MISS; on mem_valid, oins=0xA2 and ohit=1. A subsequent ireq 0x44 -> miss.
- Reset mid-refill: rst asserted in MISS -> next cycle mem_req=0, ostall=0. A later mem_valid -> no ohit, counters remain 0.
